// File: rtl/sobel_win_sched.sv
// rtl/sobel_win_sched.sv - 3x3 window scheduler sharing one sync-read image RAM with a Sobel core
module sobel_win_sched #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 96,
    parameter int AW     = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [7:0]    pix_0,
    output logic [7:0]    pix_1,
    output logic [7:0]    pix_2,
    output logic [7:0]    pix_3,
    output logic [7:0]    pix_5,
    output logic [7:0]    pix_6,
    output logic [7:0]    pix_7,
    output logic [7:0]    pix_8,
    output logic [6:0]    win_x,
    output logic [6:0]    win_y,
    output logic          border
);

    typedef enum logic [2:0] {IDLE, CHECK, FETCH, LOAD, OUT, DONE} state_t;

    localparam logic [AW:0] W1   = (AW+1)'(WIDTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [6:0]  XMAX = 7'(WIDTH - 1);
    localparam logic [6:0]  YMAX = 7'(HEIGHT - 1);

    state_t        state;
    logic [AW-1:0] c;
    logic [2:0]    k;
    logic [7:0]    slot [8];
    logic [2:0]    nidx;
    logic [AW:0]   nb;
    logic          on_border;
    logic          last;

    assign pix_0 = slot[0];
    assign pix_1 = slot[1];
    assign pix_2 = slot[2];
    assign pix_3 = slot[3];
    assign pix_5 = slot[4];
    assign pix_6 = slot[5];
    assign pix_7 = slot[6];
    assign pix_8 = slot[7];

    assign on_border = (win_x == 7'd0) || (win_x == XMAX) || (win_y == 7'd0) || (win_y == YMAX);
    assign last      = (win_x == XMAX) && (win_y == YMAX);

    // Address of the neighbour that will be requested in the next FETCH cycle.
    assign nidx = (state == FETCH) ? k + 3'd1 : 3'd0;

    always_comb begin
        case (nidx)
            3'd0:    nb = {1'b0, c} - W1 - ONE;
            3'd1:    nb = {1'b0, c} - W1;
            3'd2:    nb = {1'b0, c} - W1 + ONE;
            3'd3:    nb = {1'b0, c} - ONE;
            3'd4:    nb = {1'b0, c} + ONE;
            3'd5:    nb = {1'b0, c} + W1 - ONE;
            3'd6:    nb = {1'b0, c} + W1;
            default: nb = {1'b0, c} + W1 + ONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            win_valid <= 1'b0;
            border    <= 1'b0;
            win_x     <= 7'd0;
            win_y     <= 7'd0;
            c         <= '0;
            k         <= 3'd0;
            for (int i = 0; i < 8; i++) slot[i] <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CHECK;
                        busy  <= 1'b1;
                        win_x <= 7'd0;
                        win_y <= 7'd0;
                        c     <= '0;
                    end
                end
                CHECK: begin
                    for (int i = 0; i < 8; i++) slot[i] <= 8'h00;
                    if (on_border) begin
                        border    <= 1'b1;
                        win_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        border   <= 1'b0;
                        mem_en   <= ~nb[AW];
                        mem_addr <= nb[AW-1:0];
                        k        <= 3'd0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // Read data lags the request by one cycle, so slot k-1 lands now.
                    if (k != 3'd0) slot[k - 3'd1] <= mem_data;
                    if (k == 3'd7) begin
                        mem_en <= 1'b0;
                        state  <= LOAD;
                    end else begin
                        mem_en   <= ~nb[AW];
                        mem_addr <= nb[AW-1:0];
                        k        <= k + 3'd1;
                    end
                end
                LOAD: begin
                    slot[7]   <= mem_data;
                    win_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= CHECK;
                            c     <= c + AW'(1);
                            if (win_x == XMAX) begin
                                win_x <= 7'd0;
                                win_y <= win_y + 7'd1;
                            end else begin
                                win_x <= win_x + 7'd1;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
